// File: rtl/iobus_intr_ctrl.sv
// ---------------------------------------------------------------------------------------------
// iobus_intr_ctrl
//
// Interrupt controller for the OTTER MCU's single INTR input. Up to N_SRC edge-triggered
// sources are latched into pending bits, gated by per-source enables, and turned into a
// fixed-length INTR pulse. After a pulse the controller holds off until firmware writes ACK,
// or until nothing enabled is pending any more.
//
// Register map (relative to BASE_AD; only bits [N_SRC-1:0] exist, other read bits are 0):
//   +0x0 PENDING  R, write-1-to-clear
//   +0x4 ENABLE   R/W
//   +0x8 CLAIM    RO  {valid, 26'b0, index[4:0]}, lowest enabled pending source
//   +0xC ACK      WO  any write acknowledges; reads return 0
//
// Ports:
//   CLK         CPU clock
//   RST         synchronous, active-high reset
//   IRQ_IN      interrupt sources, synchronous to CLK; rising edge requests service
//   IOBUS_ADDR  CPU MMIO address
//   IOBUS_OUT   CPU MMIO write data
//   IOBUS_WR    CPU MMIO write strobe, one cycle per store
//   IOBUS_RD    combinational read data for this block's addresses, 0 elsewhere
//   INTR        registered interrupt request to the CPU
// ---------------------------------------------------------------------------------------------
module iobus_intr_ctrl #(
    parameter int unsigned N_SRC       = 4,
    parameter logic [31:0] BASE_AD     = 32'h11000060,
    parameter int unsigned INTR_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      IOBUS_RD,
    output logic             INTR
);

    localparam int unsigned    CntW      = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad  = CntW'(INTR_CYCLES - 1);

    localparam logic [31:0] AddrPend  = BASE_AD;
    localparam logic [31:0] AddrEn    = BASE_AD + 32'h4;
    localparam logic [31:0] AddrClaim = BASE_AD + 32'h8;
    localparam logic [31:0] AddrAck   = BASE_AD + 32'hC;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StWaitAck
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] irq_q,     irq_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q,  enable_d;
    state_e           state_q,   state_d;
    logic [CntW-1:0]  cnt_q,     cnt_d;
    logic             intr_q,    intr_d;

    // ------------------------------------------------------------------
    // Bus write decode (exact address match only)
    // ------------------------------------------------------------------
    logic wr_pend;
    logic wr_en;
    logic wr_ack;

    always_comb begin
        wr_pend = IOBUS_WR && (IOBUS_ADDR == AddrPend);
        wr_en   = IOBUS_WR && (IOBUS_ADDR == AddrEn);
        wr_ack  = IOBUS_WR && (IOBUS_ADDR == AddrAck);
    end

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^IOBUS_OUT[31:N_SRC];

    // ------------------------------------------------------------------
    // Edge detect, pending and enable
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c_mask;
    logic [N_SRC-1:0] active;

    always_comb begin
        irq_d     = IRQ_IN;
        rise      = IRQ_IN & ~irq_q;
        w1c_mask  = wr_pend ? IOBUS_OUT[N_SRC-1:0] : '0;
        // Clear first, then OR in new edges so a same-cycle set beats the clear.
        pending_d = (pending_q & ~w1c_mask) | rise;
        enable_d  = wr_en ? IOBUS_OUT[N_SRC-1:0] : enable_q;
        active    = pending_q & enable_q;
    end

    // ------------------------------------------------------------------
    // Claim: lowest-index enabled pending source
    // ------------------------------------------------------------------
    logic       claim_vld;
    logic [4:0] claim_idx;

    always_comb begin
        claim_vld = 1'b0;
        claim_idx = 5'd0;
        // Walk from the top down so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_vld = 1'b1;
                claim_idx = 5'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pulse / hold-off FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        intr_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (|active) begin
                    state_d = StPulse;
                    intr_d  = 1'b1;
                    cnt_d   = CntLoad;
                end
            end

            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWaitAck;
                end else begin
                    intr_d = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end
            end

            StWaitAck: begin
                // Leave on ACK, or once firmware has cleared/masked everything enabled.
                if (wr_ack || (active == '0)) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            intr_q    <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            intr_q    <= intr_d;
        end
    end

    assign INTR = intr_q;

    // ------------------------------------------------------------------
    // Read mux (combinational, no side effects)
    // ------------------------------------------------------------------
    always_comb begin
        IOBUS_RD = 32'h0;
        case (IOBUS_ADDR)
            AddrPend:  IOBUS_RD = 32'(pending_q);
            AddrEn:    IOBUS_RD = 32'(enable_q);
            AddrClaim: IOBUS_RD = {claim_vld, 26'b0, claim_idx};
            default:   IOBUS_RD = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_iobus_intr_ctrl.sv
// Scoreboard bench for iobus_intr_ctrl. The stimulus process drives the bus and pushes the
// value it expects for the current cycle; the monitor pops and compares at the falling edge.
module tb_iobus_intr_ctrl;

    localparam logic [31:0] BASE = 32'h11000060;
    localparam logic [31:0] A_P  = BASE;
    localparam logic [31:0] A_E  = BASE + 32'h4;
    localparam logic [31:0] A_C  = BASE + 32'h8;
    localparam logic [31:0] A_A  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    logic        intr;

    int checks   = 0;
    int failures = 0;

    // Bit 32 selects the compared output: 1 = IOBUS_RD, 0 = INTR.
    logic [32:0] exp_q[$];
    string       name_q[$];

    iobus_intr_ctrl #(
        .N_SRC      (4),
        .BASE_AD    (BASE),
        .INTR_CYCLES(2)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .IRQ_IN    (irq_in),
        .IOBUS_ADDR(addr),
        .IOBUS_OUT (wdata),
        .IOBUS_WR  (wr),
        .IOBUS_RD  (rdata),
        .INTR      (intr)
    );

    always #5 clk = ~clk;

    // Monitor: everything queued for this cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [32:0] e;
            logic [31:0] act;
            string       n;
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            act = e[32] ? rdata : {31'b0, intr};
            checks++;
            if (act !== e[31:0]) begin
                failures++;
                $display("FAIL %s: got %h expected %h", n, act, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [31:0] v, input string n);
        addr = a;
        exp_q.push_back({1'b1, v});
        name_q.push_back(n);
    endtask

    task automatic exp_intr(input logic v, input string n);
        exp_q.push_back({1'b0, 31'b0, v});
        name_q.push_back(n);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        irq_in = 4'hF;
        addr   = 32'h0;
        wdata  = 32'h0;
        wr     = 1'b0;

        // 1: reset with all sources high
        step();
        exp_rd(A_P, 32'h0, "rst_pending");   exp_intr(1'b0, "rst_intr");
        step();
        exp_rd(A_E, 32'h0, "rst_enable");    exp_intr(1'b0, "rst_intr2");
        step();
        rst = 1'b0;
        exp_rd(A_C, 32'h0, "rst_claim");
        step();
        // irq_q was reset to 0, so the held-high sources look like a fresh edge
        bus_wr(A_P, 32'hF);
        exp_rd(A_P, 32'hF, "post_rst_pending"); exp_intr(1'b0, "post_rst_intr_masked");
        step();
        irq_in = 4'h0;
        exp_rd(A_P, 32'h0, "w1c_all");
        step();

        // 2: masked, then enabled
        irq_in = 4'h4;
        step();
        exp_rd(A_P, 32'h4, "masked_pending"); exp_intr(1'b0, "masked_intr");
        step();
        exp_intr(1'b0, "masked_intr2");
        bus_wr(A_E, 32'h4);
        step();
        exp_intr(1'b0, "en_intr_lat");
        exp_rd(A_C, 32'h80000002, "claim_src2");
        step();
        exp_intr(1'b1, "pulse2_c0");
        step();
        exp_intr(1'b1, "pulse2_c1");
        step();
        exp_intr(1'b0, "pulse2_end");
        bus_wr(A_P, 32'h4);
        step();
        exp_intr(1'b0, "wait_after_w1c");
        step();
        irq_in = 4'h0;
        exp_intr(1'b0, "idle_after_clear");
        exp_rd(A_P, 32'h0, "pend_cleared2");
        step();

        // 3: priority and back-to-back service
        bus_wr(A_E, 32'hF);
        step();
        irq_in = 4'hA;
        step();
        exp_rd(A_C, 32'h80000001, "claim_prio1"); exp_intr(1'b0, "prio_lat");
        step();
        exp_intr(1'b1, "pulse3_c0");
        step();
        exp_intr(1'b1, "pulse3_c1");
        step();
        exp_intr(1'b0, "pulse3_end");
        bus_wr(A_P, 32'h2);
        step();
        bus_wr(A_A, 32'h0);
        exp_rd(A_A, 32'h0, "ack_reads_zero"); exp_intr(1'b0, "ack_cycle_intr");
        step();
        exp_intr(1'b0, "idle_after_ack");
        exp_rd(A_C, 32'h80000003, "claim_src3");
        step();
        exp_intr(1'b1, "refire_c0");
        step();
        exp_intr(1'b1, "refire_c1");
        step();
        exp_intr(1'b0, "refire_end");

        // 4: hold-off in WAIT_ACK
        irq_in = 4'hB;
        step();
        exp_rd(A_P, 32'h9, "holdoff_pending"); exp_intr(1'b0, "holdoff_intr0");
        step();
        exp_intr(1'b0, "holdoff_intr1");
        step();
        exp_intr(1'b0, "holdoff_intr2");
        bus_wr(A_P, 32'h8);
        step();
        bus_wr(A_A, 32'h0);
        exp_intr(1'b0, "holdoff_ack_cycle");
        step();
        exp_intr(1'b0, "holdoff_idle");
        exp_rd(A_C, 32'h80000000, "claim_src0");
        step();
        exp_intr(1'b1, "pulse4_c0");
        step();
        exp_intr(1'b1, "pulse4_c1");
        step();
        exp_intr(1'b0, "pulse4_end");

        // 5: set/clear collision
        irq_in = 4'hA;
        bus_wr(A_P, 32'h1);
        step();
        exp_rd(A_P, 32'h0, "pend_zero_pre5"); exp_intr(1'b0, "pre5_intr");
        step();
        bus_wr(A_E, 32'h0);
        step();
        irq_in = 4'hB;
        bus_wr(A_P, 32'h1);
        step();
        exp_rd(A_P, 32'h1, "collision_set_wins"); exp_intr(1'b0, "collision_intr");
        step();

        // 6: reset during PULSE with counter=1
        bus_wr(A_E, 32'hF);
        step();
        exp_intr(1'b0, "pre6_intr");
        step();
        exp_intr(1'b1, "pulse6_c0");
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_intr(1'b0, "rst_mid_pulse_intr"); exp_rd(A_P, 32'h0, "rst_mid_pulse_pend");
        step();
        exp_intr(1'b0, "rst_mid_pulse_idle"); exp_rd(A_E, 32'h0, "rst_mid_pulse_en");
        step();
        exp_rd(A_P, 32'hB, "post_rst6_edges"); exp_intr(1'b0, "post_rst6_intr");
        step();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
